// File: rtl/clk_en_sched_pkg.sv
// Shared types and default widths for the clock-enable scheduler.
// Optional square-wave outputs are selected by CLK_EN_SCHED_SQUARE_EN.
package clk_en_sched_pkg;

  localparam int CPreWDef  = 8;
  localparam int CPostWDef = 8;
  localparam int CChMax    = 8;

  typedef logic [$clog2(CChMax)-1:0] ch_idx_t;

  typedef struct packed {
    logic [CPostWDef-1:0] active;
    logic [CPostWDef-1:0] shadow;
    logic                 pending;
  } ch_cfg_t;

  // A single-channel build still needs a 1-bit select port.
  function automatic int unsigned sel_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_en_sched_ch.sv
// One scheduler channel: post-divider counter, shadowed reload value and tick register.
// CLK_EN_SCHED_SQUARE_EN adds a divide-by-two square output per channel.
module clk_en_sched_ch
  import clk_en_sched_pkg::*;
#(
  parameter int CPostW = CPostWDef
) (
  input  logic              AClkH,
  input  logic              AResetH,
  input  logic              AClkHEn,
  input  logic              i_base,
  input  logic              i_en,
  input  logic              i_wr,
  input  logic [CPostW-1:0] i_data,
  output logic              o_pend,
  output logic              o_tick
`ifdef CLK_EN_SCHED_SQUARE_EN
  ,output logic             o_sq
`endif
);

  ch_cfg_t           r_cfg;
  logic [CPostW-1:0] r_cnt;
  logic              r_en_d;
  logic              r_tick;

  logic [CPostW-1:0] w_act;
  logic [CPostW-1:0] w_shd;
  logic              w_rise;
  logic              w_term;
  logic              w_apply;

  assign w_act  = CPostW'(r_cfg.active);
  assign w_shd  = CPostW'(r_cfg.shadow);
  assign w_rise = i_en && !r_en_d;
  // The enable-rise cycle only loads the counter, so it can never terminate a period.
  assign w_term = i_base && i_en && r_en_d && (r_cnt == '0);
  assign w_apply = r_cfg.pending && (w_term || !i_en);

  always_ff @(posedge AClkH) begin
    if (AResetH) begin
      r_cfg  <= '0;
      r_cnt  <= '0;
      r_en_d <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_term;
      if (AClkHEn) begin
        r_en_d <= i_en;
        if (w_rise) begin
          r_cnt <= w_act;
        end else if (w_term) begin
          r_cnt <= w_apply ? w_shd : w_act;
        end else if (i_en && i_base) begin
          r_cnt <= r_cnt - CPostW'(1);
        end
        if (w_apply) begin
          r_cfg.active <= r_cfg.shadow;
        end
        // A write on the apply cycle keeps the flag: the old shadow is consumed now.
        if (i_wr) begin
          r_cfg.shadow  <= CPostWDef'(i_data);
          r_cfg.pending <= 1'b1;
        end else if (w_apply) begin
          r_cfg.pending <= 1'b0;
        end
      end
    end
  end

  assign o_pend = r_cfg.pending;
  assign o_tick = r_tick;

`ifdef CLK_EN_SCHED_SQUARE_EN
  logic r_sq;

  always_ff @(posedge AClkH) begin
    if (AResetH) begin
      r_sq <= 1'b0;
    end else if (w_term) begin
      r_sq <= ~r_sq;
    end
  end

  assign o_sq = r_sq;
`endif

endmodule

// File: rtl/clk_en_sched.sv
// Clock-enable scheduler: shared shadowed prescaler feeding CChCnt post-divider channels.
// Define CLK_EN_SCHED_SQUARE_EN to add the AClkSq square-wave outputs.
module clk_en_sched
  import clk_en_sched_pkg::*;
#(
  parameter int               CChCnt  = 4,
  parameter int               CPreW   = CPreWDef,
  parameter int               CPostW  = CPostWDef,
  parameter logic [CPreW-1:0] CPreRst = '0,
  localparam int              CSelW   = sel_width(CChCnt)
) (
  input  logic              AClkH,
  input  logic              AResetH,
  input  logic              AClkHEn,
  input  logic              APreWr,
  input  logic [CPreW-1:0]  APreData,
  input  logic              AChWr,
  input  logic [CSelW-1:0]  AChSel,
  input  logic [CPostW-1:0] AChData,
  input  logic [CChCnt-1:0] AChEn,
  output logic              ABusy,
  output logic              ABaseTick,
  output logic [CChCnt-1:0] ATick
`ifdef CLK_EN_SCHED_SQUARE_EN
  ,output logic [CChCnt-1:0] AClkSq
`endif
);

  logic [CPreW-1:0]  r_pre_cnt;
  logic [CPreW-1:0]  r_pre_act;
  logic [CPreW-1:0]  r_pre_shd;
  logic              r_pre_p;
  logic              r_base;

  logic              w_base;
  logic [CChCnt-1:0] w_wr;
  logic [CChCnt-1:0] w_pend;

  assign w_base = AClkHEn && (r_pre_cnt == '0);

  always_ff @(posedge AClkH) begin
    if (AResetH) begin
      r_pre_cnt <= CPreRst;
      r_pre_act <= CPreRst;
      r_pre_shd <= CPreRst;
      r_pre_p   <= 1'b0;
      r_base    <= 1'b0;
    end else begin
      r_base <= w_base;
      if (AClkHEn) begin
        if (w_base) begin
          r_pre_cnt <= r_pre_p ? r_pre_shd : r_pre_act;
          if (r_pre_p) begin
            r_pre_act <= r_pre_shd;
          end
        end else begin
          r_pre_cnt <= r_pre_cnt - CPreW'(1);
        end
        if (APreWr) begin
          r_pre_shd <= APreData;
          r_pre_p   <= 1'b1;
        end else if (w_base) begin
          r_pre_p <= 1'b0;
        end
      end
    end
  end

  for (genvar gi = 0; gi < CChCnt; gi++) begin : g_ch
    // Out-of-range selects match no channel and are dropped.
    assign w_wr[gi] = AChWr && (ch_idx_t'(AChSel) == ch_idx_t'(gi));

    clk_en_sched_ch #(
      .CPostW(CPostW)
    ) u_ch (
      .AClkH   (AClkH),
      .AResetH (AResetH),
      .AClkHEn (AClkHEn),
      .i_base  (w_base),
      .i_en    (AChEn[gi]),
      .i_wr    (w_wr[gi]),
      .i_data  (AChData),
      .o_pend  (w_pend[gi]),
      .o_tick  (ATick[gi])
`ifdef CLK_EN_SCHED_SQUARE_EN
      ,.o_sq   (AClkSq[gi])
`endif
    );
  end

  assign ABaseTick = r_base;
  assign ABusy     = r_pre_p || (|w_pend);

endmodule
